// File: rtl/plasma_pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer.
//   - FSM state encoding
//   - retry register width
//   - counter sizing helpers
package plasma_pll_seq_pkg;

    localparam logic [2:0] S_PLL_RST   = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_GAP       = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;
    localparam logic [2:0] S_FAIL      = 3'd5;

    localparam int unsigned RETRY_W = 4;

    // Bits needed to hold the value n (at least one).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n == 0) ? 1 : $clog2(n + 32'd1);
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/plasma_de1_soc_pll_reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and the PLL / SoC reset tree.
//   master: sequencer side (drives PLL reset, domain resets and status)
//   slave : board side (drives pll_locked and soft_restart)
interface plasma_de1_soc_pll_reset_sequencer_if;
    import plasma_pll_seq_pkg::*;

    logic               pll_locked;
    logic               soft_restart;
    logic               pll_rst;
    logic               sdram_reset_n;
    logic               sys_reset_n;
    logic               ready;
    logic               fail;
    logic [RETRY_W-1:0] retry_count;

    modport master (
        input  pll_locked, soft_restart,
        output pll_rst, sdram_reset_n, sys_reset_n, ready, fail, retry_count
    );

    modport slave (
        output pll_locked, soft_restart,
        input  pll_rst, sdram_reset_n, sys_reset_n, ready, fail, retry_count
    );

endinterface

// File: rtl/plasma_bit_sync.sv
// Two-flop synchroniser for a single asynchronous level.
//   clk, rst_n : clock, async active-low reset (output resets to 0)
//   d          : asynchronous input
//   q          : synchronised output, two cycles behind d
module plasma_bit_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/plasma_de1_soc_pll_reset_sequencer.sv
// PLL bring-up and lock supervisor: pulses pll_rst, filters lock, releases the
// SDRAM then system resets, re-sequences on lock loss and retries on lock timeout.
//   clk     : free-running board reference clock
//   reset_n : async active-low reset
//   bus     : master modport (pll_locked/soft_restart in; resets and status out)
module plasma_de1_soc_pll_reset_sequencer
    import plasma_pll_seq_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned RELEASE_GAP_CYCLES  = 8,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic clk,
    input  logic reset_n,
    plasma_de1_soc_pll_reset_sequencer_if.master bus
);

    localparam int unsigned PH_W  = cnt_width(max3(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES,
                                                   RELEASE_GAP_CYCLES));
    localparam int unsigned TMO_W = cnt_width(LOCK_TIMEOUT_CYCLES);

    localparam logic [PH_W-1:0]    PH_RST_LAST    = PH_W'(RST_PULSE_CYCLES - 1);
    // STABLE is entered on the first synced-lock cycle; it then needs the full
    // stable count on top of that entry cycle.
    localparam logic [PH_W-1:0]    PH_STABLE_LAST = PH_W'(LOCK_STABLE_CYCLES);
    localparam logic [PH_W-1:0]    PH_GAP_LAST    = PH_W'(RELEASE_GAP_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST       = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX      = RETRY_W'(MAX_RETRIES);

    logic               lock_s;
    logic [2:0]         state, state_nx;
    logic [PH_W-1:0]    phase_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [RETRY_W-1:0] retry_cnt, retry_nx;
    logic               tmo_hit, enter;
    logic               pll_rst_q, sdram_q, sys_q, ready_q, fail_q;
    logic               pll_rst_nx, sdram_nx, sys_nx, ready_nx, fail_nx;

    plasma_bit_sync u_lock_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (bus.pll_locked),
        .q     (lock_s)
    );

    assign tmo_hit = ((state == S_WAIT_LOCK) || (state == S_STABLE)) && (tmo_cnt == TMO_LAST);
    // Any state entry (including a restart while already in PLL_RST) reloads the phase counter.
    assign enter   = (state_nx != state) || bus.soft_restart;

    // Next-state, retry and registered-output decode.
    always_comb begin
        state_nx = state;
        retry_nx = retry_cnt;
        if (bus.soft_restart) begin
            state_nx = S_PLL_RST;
            retry_nx = '0;
        end else begin
            case (state)
                S_PLL_RST: begin
                    if (phase_cnt == PH_RST_LAST) state_nx = S_WAIT_LOCK;
                end
                S_WAIT_LOCK, S_STABLE: begin
                    if ((state == S_STABLE) && !lock_s) begin
                        state_nx = S_WAIT_LOCK;
                    end else if (tmo_hit) begin
                        if (retry_cnt >= RETRY_MAX) begin
                            state_nx = S_FAIL;
                        end else begin
                            state_nx = S_PLL_RST;
                            retry_nx = retry_cnt + RETRY_W'(1);
                        end
                    end else if ((state == S_WAIT_LOCK) && lock_s) begin
                        state_nx = S_STABLE;
                    end else if ((state == S_STABLE) && (phase_cnt == PH_STABLE_LAST)) begin
                        state_nx = S_GAP;
                    end
                end
                S_GAP: begin
                    if (!lock_s)                       state_nx = S_PLL_RST;
                    else if (phase_cnt == PH_GAP_LAST) state_nx = S_RUN;
                end
                S_RUN: begin
                    if (!lock_s) state_nx = S_PLL_RST;
                end
                S_FAIL:  state_nx = S_FAIL;
                default: state_nx = S_PLL_RST;
            endcase
        end

        pll_rst_nx = (state_nx == S_PLL_RST) || (state_nx == S_FAIL);
        sdram_nx   = (state_nx == S_GAP) || (state_nx == S_RUN);
        sys_nx     = (state_nx == S_RUN);
        ready_nx   = (state_nx == S_RUN);
        fail_nx    = (state_nx == S_FAIL);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_PLL_RST;
        else          state <= state_nx;
    end

    // Counters, retry register and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_cnt <= '0;
            tmo_cnt   <= '0;
            retry_cnt <= '0;
            pll_rst_q <= 1'b1;
            sdram_q   <= 1'b0;
            sys_q     <= 1'b0;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            if (enter)                phase_cnt <= '0;
            else if (phase_cnt != '1) phase_cnt <= phase_cnt + PH_W'(1);

            // Timeout spans the whole WAIT_LOCK/STABLE episode, bounces included.
            if ((state == S_WAIT_LOCK) || (state == S_STABLE)) begin
                if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + TMO_W'(1);
            end else begin
                tmo_cnt <= '0;
            end

            retry_cnt <= retry_nx;
            pll_rst_q <= pll_rst_nx;
            sdram_q   <= sdram_nx;
            sys_q     <= sys_nx;
            ready_q   <= ready_nx;
            fail_q    <= fail_nx;
        end
    end

    assign bus.pll_rst       = pll_rst_q;
    assign bus.sdram_reset_n = sdram_q;
    assign bus.sys_reset_n   = sys_q;
    assign bus.ready         = ready_q;
    assign bus.fail          = fail_q;
    assign bus.retry_count   = retry_cnt;

endmodule

// File: tb/tb_plasma_de1_soc_pll_reset_sequencer.sv
// Directed bench for the PLL reset sequencer with small parameters
// (pulse 4, stable 8, timeout 32, gap 2, retries 2).
// Output vector order: {pll_rst, sdram_reset_n, sys_reset_n, ready, fail, retry_count[3:0]}.
module tb_plasma_de1_soc_pll_reset_sequencer;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    plasma_de1_soc_pll_reset_sequencer_if bus ();

    plasma_de1_soc_pll_reset_sequencer #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .RELEASE_GAP_CYCLES  (2),
        .MAX_RETRIES         (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", tag, got[8:0], exp[8:0]);
        end
    endtask

    function automatic logic [8:0] outs();
        return {bus.pll_rst, bus.sdram_reset_n, bus.sys_reset_n, bus.ready, bus.fail,
                bus.retry_count};
    endfunction

    function automatic logic [8:0] exp_o(input bit prst, input bit sd, input bit sy,
                                         input bit rd, input bit fl, input int rc);
        return {prst, sd, sy, rd, fl, 4'(rc)};
    endfunction

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold reset, check reset values, release on a falling edge (next rising edge is edge 1).
    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        bus.pll_locked   = 1'b0;
        bus.soft_restart = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check(tag, 32'(outs()), 32'(exp_o(1, 0, 0, 0, 0, 0)));
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // 1: nominal bring-up, lock rises after edge 10 (first sampled at edge 11)
        do_reset("s1_reset_vals");
        tick(3);  check("s1_pulse_hold",  32'(outs()), 32'(exp_o(1, 0, 0, 0, 0, 0)));
        tick(1);  check("s1_pulse_end",   32'(outs()), 32'(exp_o(0, 0, 0, 0, 0, 0)));
        tick(6);  bus.pll_locked = 1'b1;                                   // edge 10
        tick(11); check("s1_pre_sdram",   32'(outs()), 32'(exp_o(0, 0, 0, 0, 0, 0)));
        tick(1);  check("s1_sdram_up",    32'(outs()), 32'(exp_o(0, 1, 0, 0, 0, 0))); // edge 22
        tick(1);  check("s1_gap",         32'(outs()), 32'(exp_o(0, 1, 0, 0, 0, 0)));
        tick(1);  check("s1_run",         32'(outs()), 32'(exp_o(0, 1, 1, 1, 0, 0))); // edge 24

        // 4: lock loss in RUN, full re-sequence
        tick(6);  bus.pll_locked = 1'b0;                                   // edge 30
        tick(2);  check("s4_run_hold",    32'(outs()), 32'(exp_o(0, 1, 1, 1, 0, 0)));
        tick(1);  check("s4_drop",        32'(outs()), 32'(exp_o(1, 0, 0, 0, 0, 0))); // edge 33
        tick(3);  check("s4_pulse_hold",  32'(outs()), 32'(exp_o(1, 0, 0, 0, 0, 0)));
        tick(1);  check("s4_pulse_end",   32'(outs()), 32'(exp_o(0, 0, 0, 0, 0, 0))); // edge 37
        bus.pll_locked = 1'b1;
        tick(11); check("s4_pre_sdram",   32'(outs()), 32'(exp_o(0, 0, 0, 0, 0, 0)));
        tick(1);  check("s4_sdram_up",    32'(outs()), 32'(exp_o(0, 1, 0, 0, 0, 0))); // edge 49
        tick(2);  check("s4_rerun",       32'(outs()), 32'(exp_o(0, 1, 1, 1, 0, 0))); // edge 51

        // 2: lock bounce during STABLE (low for 3 cycles) restarts the stable count
        do_reset("s2_reset_vals");
        tick(10); bus.pll_locked = 1'b1;                                   // edge 10
        tick(5);  bus.pll_locked = 1'b0;                                   // edge 15, STABLE
        check("s2_in_stable",             32'(outs()), 32'(exp_o(0, 0, 0, 0, 0, 0)));
        tick(3);  bus.pll_locked = 1'b1;                                   // edge 18
        check("s2_bounce_no_pulse",       32'(outs()), 32'(exp_o(0, 0, 0, 0, 0, 0)));
        tick(11); check("s2_pre_sdram",   32'(outs()), 32'(exp_o(0, 0, 0, 0, 0, 0))); // edge 29
        tick(1);  check("s2_sdram_up",    32'(outs()), 32'(exp_o(0, 1, 0, 0, 0, 0))); // edge 30
        tick(2);  check("s2_run",         32'(outs()), 32'(exp_o(0, 1, 1, 1, 0, 0))); // edge 32

        // 3: lock never arrives -> two retries then FAIL
        do_reset("s3_reset_vals");
        tick(35); check("s3_pre_tmo1",    32'(outs()), 32'(exp_o(0, 0, 0, 0, 0, 0)));
        tick(1);  check("s3_tmo1",        32'(outs()), 32'(exp_o(1, 0, 0, 0, 0, 1))); // edge 36
        tick(3);  check("s3_retry_hold",  32'(outs()), 32'(exp_o(1, 0, 0, 0, 0, 1)));
        tick(1);  check("s3_retry_end",   32'(outs()), 32'(exp_o(0, 0, 0, 0, 0, 1))); // edge 40
        tick(31); check("s3_pre_tmo2",    32'(outs()), 32'(exp_o(0, 0, 0, 0, 0, 1)));
        tick(1);  check("s3_tmo2",        32'(outs()), 32'(exp_o(1, 0, 0, 0, 0, 2))); // edge 72
        tick(35); check("s3_pre_fail",    32'(outs()), 32'(exp_o(0, 0, 0, 0, 0, 2))); // edge 107
        tick(1);  check("s3_fail",        32'(outs()), 32'(exp_o(1, 0, 0, 0, 1, 2))); // edge 108
        tick(20); check("s3_fail_stuck",  32'(outs()), 32'(exp_o(1, 0, 0, 0, 1, 2))); // edge 128

        // 5: soft_restart out of FAIL, then soft_restart colliding with a timeout
        bus.soft_restart = 1'b1;
        tick(1);  bus.soft_restart = 1'b0;                                 // edge 129
        check("s5_restart",               32'(outs()), 32'(exp_o(1, 0, 0, 0, 0, 0)));
        tick(3);  check("s5_pulse_hold",  32'(outs()), 32'(exp_o(1, 0, 0, 0, 0, 0)));
        tick(1);  check("s5_pulse_end",   32'(outs()), 32'(exp_o(0, 0, 0, 0, 0, 0))); // edge 133
        tick(31); check("s5_pre_tmo",     32'(outs()), 32'(exp_o(0, 0, 0, 0, 0, 0))); // edge 164
        bus.soft_restart = 1'b1;
        tick(1);  bus.soft_restart = 1'b0;                                 // edge 165
        check("s5_restart_vs_tmo",        32'(outs()), 32'(exp_o(1, 0, 0, 0, 0, 0)));

        // 6: async reset during GAP, then resume with lock already present
        do_reset("s6_reset_vals");
        tick(10); bus.pll_locked = 1'b1;
        tick(12); check("s6_gap",         32'(outs()), 32'(exp_o(0, 1, 0, 0, 0, 0))); // edge 22
        #3 reset_n = 1'b0;
        #2 check("s6_async_rst",          32'(outs()), 32'(exp_o(1, 0, 0, 0, 0, 0)));
        @(negedge clk);
        reset_n = 1'b1;
        tick(3);  check("s6_pulse_hold",  32'(outs()), 32'(exp_o(1, 0, 0, 0, 0, 0)));
        tick(1);  check("s6_pulse_end",   32'(outs()), 32'(exp_o(0, 0, 0, 0, 0, 0)));
        tick(9);  check("s6_pre_sdram",   32'(outs()), 32'(exp_o(0, 0, 0, 0, 0, 0))); // edge 13
        tick(1);  check("s6_sdram_up",    32'(outs()), 32'(exp_o(0, 1, 0, 0, 0, 0))); // edge 14
        tick(2);  check("s6_run",         32'(outs()), 32'(exp_o(0, 1, 1, 1, 0, 0))); // edge 16

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
